// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DMA  = 1;

    typedef enum logic {S_NORMAL, S_FORCE} arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Misaligned byte address or word index outside the memory.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_grant.sv
// Two-way combinational grant: the port selected by prio wins when both are valid.
module arb_grant2 (
    input  logic       enable,
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid[prio]) begin
                grant[prio] = 1'b1;
            end else if (valid[~prio]) begin
                grant[~prio] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between the pipeline MEM stage (port 0) and the DMA loader (port 1) for one
// single-port data memory; one access per cycle, registered one-cycle responses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned RR_MODE    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [1:0]  rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          prio;
    logic [1:0]    grant;
    logic          any_grant;
    logic          err;
    mem_req_t      sel;

    arb_grant2 u_grant (
        .enable (~reset),
        .valid  (req_valid),
        .prio   (prio),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_NORMAL;
            starve_cnt_q <= '0;
            rr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        if (RR_MODE != 0) begin
            if (grant[rr_ptr_q]) begin
                rr_ptr_d = ~rr_ptr_q;
            end
        end else begin
            if (req_valid[PORT_DMA] && !grant[PORT_DMA]) begin
                if (starve_cnt_q != CW'(STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + CW'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
            unique case (state_q)
                S_NORMAL: begin
                    if (req_valid[PORT_DMA] && !grant[PORT_DMA] &&
                        starve_cnt_q == CW'(STARVE_MAX - 1)) begin
                        state_d = S_FORCE;
                    end
                end
                S_FORCE: begin
                    if (grant[PORT_DMA] || !req_valid[PORT_DMA]) begin
                        state_d = S_NORMAL;
                    end
                end
                default: state_d = S_NORMAL;
            endcase
        end
    end

    always_comb begin
        if (RR_MODE != 0) begin
            prio = rr_ptr_q;
        end else begin
            prio = (state_q == S_FORCE);
        end
    end

    // Granted request drives the memory; idle cycles present an all-zero port.
    always_comb begin
        sel = '0;
        if (grant[PORT_DMA]) begin
            sel = {req_we[PORT_DMA], req_addr1, req_wdata1};
        end else if (grant[PORT_CORE]) begin
            sel = {req_we[PORT_CORE], req_addr0, req_wdata0};
        end
    end

    assign any_grant = |grant;
    assign err       = any_grant && addr_err(sel.addr, DEPTH);
    assign req_ready = grant;
    assign mem_we    = any_grant && sel.we && !err;
    assign mem_a     = sel.addr;
    assign mem_wd    = sel.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 2'b00;
            rsp_err   <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= grant;
            rsp_err   <= err ? grant : 2'b00;
            if (any_grant) begin
                rsp_rdata <= (!sel.we && !err) ? mem_rd : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a priority-mode and a round-robin instance share stimulus and are
// checked every cycle against a request-level model plus directed literal expectations.
module tb_dmem_arbiter;

    localparam int DEPTH      = 64;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_we;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [1:0]  rr_req_ready, rr_rsp_valid, rr_rsp_err;
    logic [31:0] rr_rsp_rdata, rr_mem_a, rr_mem_wd, rr_mem_rd;
    logic        rr_mem_we;

    logic [31:0] mem    [64] = '{default: 32'h0};
    logic [31:0] rr_mem [64] = '{default: 32'h0};
    logic [31:0] m_mem  [64] = '{default: 32'h0};

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .RR_MODE(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(rr_req_ready), .rsp_valid(rr_rsp_valid), .rsp_err(rr_rsp_err),
        .rsp_rdata(rr_rsp_rdata), .mem_we(rr_mem_we), .mem_a(rr_mem_a), .mem_wd(rr_mem_wd),
        .mem_rd(rr_mem_rd)
    );

    assign mem_rd    = mem[mem_a[7:2]];
    assign rr_mem_rd = rr_mem[rr_mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
        if (rr_mem_we) rr_mem[rr_mem_a[7:2]] <= rr_mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // Model state: expected registered responses and arbitration history.
    logic [1:0]  e_vld = 2'b00, e_err = 2'b00;
    logic [31:0] e_rdata = 32'h0;
    logic [1:0]  rr_e_vld = 2'b00, rr_e_err = 2'b00;
    logic [31:0] rr_e_rdata = 32'h0;
    int          m_wait = 0;
    int          rr_ptr = 0;

    always @(negedge clk) begin
        logic [1:0]  g, rg;
        logic [31:0] a, d, ra;
        logic        w, rw, bad, rbad;
        #2;
        if (reset) begin
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_mem_we", 32'(mem_we), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_rdata", rsp_rdata, 32'h0);
            check("rst_rr_ready", 32'(rr_req_ready), 32'h0);
            e_vld = 2'b00; e_err = 2'b00; e_rdata = 32'h0; m_wait = 0;
            rr_e_vld = 2'b00; rr_e_err = 2'b00; rr_e_rdata = 32'h0; rr_ptr = 0;
        end else begin
            check("rsp_valid", 32'(rsp_valid), 32'(e_vld));
            check("rsp_err", 32'(rsp_err & rsp_valid), 32'(e_err));
            check("rsp_rdata", rsp_rdata, e_rdata);
            check("rr_rsp_valid", 32'(rr_rsp_valid), 32'(rr_e_vld));
            check("rr_rsp_err", 32'(rr_rsp_err & rr_rsp_valid), 32'(rr_e_err));
            check("rr_rsp_rdata", rr_rsp_rdata, rr_e_rdata);

            // Port 1 wins when port 0 is idle or it has already waited STARVE_MAX cycles.
            g = 2'b00;
            if (req_valid[1] && (!req_valid[0] || m_wait >= STARVE_MAX)) g = 2'b10;
            else if (req_valid[0]) g = 2'b01;
            rg = (req_valid == 2'b11) ? ((rr_ptr == 1) ? 2'b10 : 2'b01) : req_valid;

            a  = g[1] ? req_addr1 : (g[0] ? req_addr0 : 32'h0);
            d  = g[1] ? req_wdata1 : (g[0] ? req_wdata0 : 32'h0);
            w  = g[1] ? req_we[1] : (g[0] ? req_we[0] : 1'b0);
            ra = rg[1] ? req_addr1 : (rg[0] ? req_addr0 : 32'h0);
            rw = rg[1] ? req_we[1] : (rg[0] ? req_we[0] : 1'b0);
            bad  = (g != 2'b00) && is_bad(a);
            rbad = (rg != 2'b00) && is_bad(ra);

            check("req_ready", 32'(req_ready), 32'(g));
            check("mem_we", 32'(mem_we), 32'((g != 2'b00) && w && !bad));
            check("mem_a", mem_a, a);
            check("mem_wd", mem_wd, d);
            check("rr_req_ready", 32'(rr_req_ready), 32'(rg));

            // Both instances see identical writes, so one memory image serves both.
            rr_e_vld = rg;
            rr_e_err = rbad ? rg : 2'b00;
            if (rg != 2'b00) rr_e_rdata = (!rw && !rbad) ? m_mem[ra[7:2]] : 32'h0;
            e_vld = g;
            e_err = bad ? g : 2'b00;
            if (g != 2'b00) begin
                e_rdata = (!w && !bad) ? m_mem[a[7:2]] : 32'h0;
                if (w && !bad) m_mem[a[7:2]] = d;
            end
            m_wait = (req_valid[1] && !g[1]) ? m_wait + 1 : 0;
            if (rg[rr_ptr]) rr_ptr = 1 - rr_ptr;
        end
    end

    logic [1:0] last_ready, last_rr_ready;
    logic       last_mem_we;

    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
        req_valid = v; req_we = we;
        req_addr0 = a0; req_wdata0 = d0; req_addr1 = a1; req_wdata1 = d1;
        #1;
        last_ready    = req_ready;
        last_rr_ready = rr_req_ready;
        last_mem_we   = mem_we;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b11; req_we = 2'b11;
        req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
        @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        cyc(2'b01, 2'b01, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
        check("wr_ack_valid", 32'(rsp_valid), 32'h1);
        check("wr_ack_err", 32'(rsp_err), 32'h0);
        check("wr_mem_we", 32'(last_mem_we), 32'h1);
        cyc(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        check("rd_valid", 32'(rsp_valid), 32'h1);
        check("rd_data", rsp_rdata, 32'hDEADBEEF);
        cyc(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("idle_valid", 32'(rsp_valid), 32'h0);
        check("idle_hold", rsp_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 10; i++) begin
            cyc(2'b11, 2'b00, 32'h10, 32'h0, 32'h20, 32'h0);
            check("starve_grant", 32'(last_ready), (i % 5 == 4) ? 32'h2 : 32'h1);
        end
        cyc(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        cyc(2'b01, 2'b01, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0);
        cyc(2'b10, 2'b10, 32'h0, 32'h0, 32'h102, 32'hFFFFFFFF);
        check("misalign_ready", 32'(last_ready), 32'h2);
        check("misalign_mem_we", 32'(last_mem_we), 32'h0);
        check("misalign_err", 32'(rsp_err), 32'h2);
        cyc(2'b10, 2'b10, 32'h0, 32'h0, 32'h100, 32'hFFFFFFFF);
        check("range_ready", 32'(last_ready), 32'h2);
        check("range_mem_we", 32'(last_mem_we), 32'h0);
        check("range_err", 32'(rsp_err), 32'h2);
        cyc(2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("word0_valid", 32'(rsp_valid), 32'h2);
        check("word0_intact", rsp_rdata, 32'hA5A5A5A5);

        cyc(2'b01, 2'b01, 32'h20, 32'h1234, 32'h0, 32'h0);
        cyc(2'b10, 2'b00, 32'h0, 32'h0, 32'h20, 32'h0);
        check("raw_valid", 32'(rsp_valid), 32'h2);
        check("raw_data", rsp_rdata, 32'h1234);
        cyc(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // Four port-0 wins leave port 1 forced with a port-0 response pending.
        for (int i = 0; i < 4; i++) cyc(2'b11, 2'b00, 32'h10, 32'h0, 32'h20, 32'h0);
        check("pre_reset_valid", 32'(rsp_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rsp_err", 32'(rsp_err), 32'h0);
        check("async_rsp_rdata", rsp_rdata, 32'h0);
        check("async_ready", 32'(req_ready), 32'h0);
        check("async_mem_we", 32'(mem_we), 32'h0);
        check("async_mem_a", mem_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 2'b00, 32'h10, 32'h0, 32'h20, 32'h0);
            check("post_reset_grant", 32'(last_ready), 32'h1);
            check("rr_alternate", 32'(last_rr_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
        end
        cyc(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        cyc(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
